// File: rtl/pc_pkg.sv
// Shared encodings for the program sequencer: PC update selects,
// branch condition selects and their field widths.
`timescale 1ns/1ps
package pc_pkg;

  localparam int PS_W = 3;
  localparam int BC_W = 2;

  // PC update select. Code 7 is unused and is treated as an illegal operation.
  typedef enum logic [PS_W-1:0] {
    PS_HOLD  = 3'd0,
    PS_INC   = 3'd1,
    PS_RJMP  = 3'd2,
    PS_AJMP  = 3'd3,
    PS_CALL  = 3'd4,
    PS_RCALL = 3'd5,
    PS_RET   = 3'd6
  } ps_e;

  // Branch condition select, evaluated against the D operand.
  typedef enum logic [BC_W-1:0] {
    BC_ZERO   = 2'd0,
    BC_NZERO  = 2'd1,
    BC_NEG    = 2'd2,
    BC_ALWAYS = 2'd3
  } bc_e;

endpackage

// File: rtl/program_sequencer_if.sv
// Decoder-to-sequencer bus: control inputs from the decoder and the
// PC / stack status returned to it.
`timescale 1ns/1ps
interface program_sequencer_if
  import pc_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int HW = 4
);

  logic            stall;
  logic [PS_W-1:0] PS;
  logic [BC_W-1:0] BC;
  logic [DW-1:0]   D;
  logic [HW-1:0]   AA;
  logic [HW-1:0]   BA;
  logic [AW-1:0]   instructionAddress;
  logic            stackEmpty;
  logic            stackFull;
  logic            fault;

  // Decoder side drives the controls and observes the PC and status.
  modport master (
    output stall, PS, BC, D, AA, BA,
    input  instructionAddress, stackEmpty, stackFull, fault
  );

  // Sequencer side consumes the controls and produces the PC and status.
  modport slave (
    input  stall, PS, BC, D, AA, BA,
    output instructionAddress, stackEmpty, stackFull, fault
  );

endinterface

// File: rtl/return_address_stack.sv
// LIFO of return addresses. Push onto a full stack and pop from an empty
// stack are ignored here; the sequencer decides whether that is a fault.
`timescale 1ns/1ps
module return_address_stack #(
  parameter int AW        = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [AW-1:0] i_pushData,
  output logic [AW-1:0] o_topData,
  output logic          o_empty,
  output logic          o_full
);

  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int IW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [AW-1:0] r_stack [RAS_DEPTH];
  logic [CW-1:0] r_count;
  logic          r_empty;
  logic          r_full;

  logic [CW-1:0] w_countM1;
  logic [IW-1:0] w_wrIdx;
  logic [IW-1:0] w_topIdx;
  logic          w_doPush;
  logic          w_doPop;

  // Push has priority so a simultaneous request can never corrupt the count.
  assign w_doPush  = i_push && !r_full;
  assign w_doPop   = i_pop && !r_empty && !i_push;
  assign w_countM1 = r_count - CW'(1);
  assign w_wrIdx   = r_count[IW-1:0];
  assign w_topIdx  = w_countM1[IW-1:0];

  // Occupancy count with empty/full flags kept in step with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else if (w_doPush) begin
      r_count <= r_count + CW'(1);
      r_empty <= 1'b0;
      r_full  <= (r_count == CW'(RAS_DEPTH - 1));
    end else if (w_doPop) begin
      r_count <= w_countM1;
      r_full  <= 1'b0;
      r_empty <= (r_count == CW'(1));
    end
  end

  // Entry storage; contents are meaningless until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_stack[w_wrIdx] <= i_pushData;
    end
  end

  assign o_topData = r_stack[w_topIdx];
  assign o_empty   = r_empty;
  assign o_full    = r_full;

endmodule

// File: rtl/program_sequencer.sv
// Program counter with conditional relative/absolute jumps, call/return
// through a hardware return-address stack, stall and a sticky fault flag.
`timescale 1ns/1ps
module program_sequencer
  import pc_pkg::*;
#(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int HW        = 4,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  program_sequencer_if.slave bus
);

  logic [AW-1:0]          r_pc;
  logic                   r_fault;

  logic                   w_taken;
  logic signed [2*HW-1:0] w_offset;
  logic [AW-1:0]          w_offsetExt;
  logic [AW-1:0]          w_pcInc;
  logic [AW-1:0]          w_pcRel;
  logic [AW-1:0]          w_absTarget;
  logic [AW-1:0]          w_nextPc;
  logic [AW-1:0]          w_rasTop;
  logic                   w_pushReq;
  logic                   w_popReq;
  logic                   w_faultEvent;
  logic                   w_rasEmpty;
  logic                   w_rasFull;

  // Offset is {AA,BA} as a two's-complement value; the signed cast extends it.
  assign w_offset    = {bus.AA, bus.BA};
  assign w_offsetExt = AW'(w_offset);
  assign w_pcInc     = r_pc + AW'(1);
  assign w_pcRel     = r_pc + w_offsetExt;
  assign w_absTarget = AW'(bus.D);

  // Branch condition evaluated on the D operand.
  always_comb begin
    w_taken = 1'b0;
    case (bus.BC)
      BC_ZERO:   w_taken = (bus.D == '0);
      BC_NZERO:  w_taken = (bus.D != '0);
      BC_NEG:    w_taken = bus.D[DW-1];
      BC_ALWAYS: w_taken = 1'b1;
      default:   w_taken = 1'b0;
    endcase
  end

  // Next-PC selection, stack requests and fault detection for this cycle.
  always_comb begin
    w_nextPc     = r_pc;
    w_pushReq    = 1'b0;
    w_popReq     = 1'b0;
    w_faultEvent = 1'b0;
    case (bus.PS)
      PS_HOLD: w_nextPc = r_pc;
      PS_INC:  w_nextPc = w_pcInc;
      PS_RJMP: w_nextPc = w_taken ? w_pcRel : w_pcInc;
      PS_AJMP: w_nextPc = w_taken ? w_absTarget : w_pcInc;
      PS_CALL, PS_RCALL: begin
        if (w_taken) begin
          w_nextPc = (bus.PS == PS_CALL) ? w_absTarget : w_pcRel;
          if (w_rasFull) begin
            w_faultEvent = 1'b1;
          end else begin
            w_pushReq = 1'b1;
          end
        end else begin
          w_nextPc = w_pcInc;
        end
      end
      PS_RET: begin
        if (w_taken) begin
          if (w_rasEmpty) begin
            w_faultEvent = 1'b1;
          end else begin
            w_popReq = 1'b1;
            w_nextPc = w_rasTop;
          end
        end else begin
          w_nextPc = w_pcInc;
        end
      end
      default: w_faultEvent = 1'b1;
    endcase
  end

  // PC and sticky fault; a stalled cycle leaves both untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc    <= '0;
      r_fault <= 1'b0;
    end else if (!bus.stall) begin
      r_pc <= w_nextPc;
      if (w_faultEvent) begin
        r_fault <= 1'b1;
      end
    end
  end

  return_address_stack #(
    .AW        (AW),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_pushReq && !bus.stall),
    .i_pop      (w_popReq && !bus.stall),
    .i_pushData (w_pcInc),
    .o_topData  (w_rasTop),
    .o_empty    (w_rasEmpty),
    .o_full     (w_rasFull)
  );

  assign bus.instructionAddress = r_pc;
  assign bus.stackEmpty         = w_rasEmpty;
  assign bus.stackFull          = w_rasFull;
  assign bus.fault              = r_fault;

endmodule
